// File: rtl/l1_access_arbiter.sv
// l1_access_arbiter
// Round-robin front end for a single-lookup L1 cache shared by instruction
// fetch (port 0) and data (port 1). One transaction in flight at a time:
// grant, pulse find_start, wait for updated (or watchdog), respond, repeat.
// Also keeps saturating hit/miss/timeout statistics and a sticky timeout flag.
module l1_access_arbiter #(
  parameter int BLOCK_OFFSET_BITS = 4,
  parameter int SET_INDEX_BITS    = 9,
  parameter int TAG_BITS          = 32 - SET_INDEX_BITS - BLOCK_OFFSET_BITS,
  parameter int TIMEOUT           = 255,
  parameter int COUNT_WIDTH       = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_valid,
  input  logic [31:0]                  req0_addr,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [31:0]                  req1_addr,
  output logic                         req1_ready,
  output logic                         rsp_valid,
  output logic                         rsp_id,
  output logic                         rsp_hit,
  output logic                         rsp_timeout,
  output logic                         cache_find_start,
  output logic [TAG_BITS-1:0]          cache_tag,
  output logic [SET_INDEX_BITS-1:0]    cache_index,
  output logic [BLOCK_OFFSET_BITS-1:0] cache_block_offset,
  input  logic                         cache_found,
  input  logic                         cache_updated,
  output logic [COUNT_WIDTH-1:0]       hit_count,
  output logic [COUNT_WIDTH-1:0]       miss_count,
  output logic [COUNT_WIDTH-1:0]       timeout_count,
  output logic                         busy,
  output logic                         timeout_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Last watchdog value before the transaction is abandoned.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e                         state_q, state_d;
  logic                           last_grant_q, last_grant_d;
  logic                           id_q, id_d;
  logic [TAG_BITS-1:0]            tag_q, tag_d;
  logic [SET_INDEX_BITS-1:0]      index_q, index_d;
  logic [BLOCK_OFFSET_BITS-1:0]   offset_q, offset_d;
  logic [7:0]                     wd_q, wd_d;
  logic                           hit_q, hit_d;
  logic                           timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0]         hit_cnt_q, hit_cnt_d;
  logic [COUNT_WIDTH-1:0]         miss_cnt_q, miss_cnt_d;
  logic [COUNT_WIDTH-1:0]         to_cnt_q, to_cnt_d;
  logic                           to_flag_q, to_flag_d;
  logic                           grant1;
  logic [31:0]                    grant_addr;

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // Next-state, arbitration, watchdog and statistics update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    tag_d        = tag_q;
    index_d      = index_q;
    offset_d     = offset_q;
    wd_d         = wd_q;
    hit_d        = hit_q;
    timeout_d    = timeout_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    to_cnt_d     = to_cnt_q;
    to_flag_d    = to_flag_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    grant1       = req1_valid && (!req0_valid || !last_grant_q);
    grant_addr   = grant1 ? req1_addr : req0_addr;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = !grant1;
          req1_ready   = grant1;
          id_d         = grant1;
          last_grant_d = grant1;
          tag_d        = grant_addr[31 -: TAG_BITS];
          index_d      = grant_addr[BLOCK_OFFSET_BITS +: SET_INDEX_BITS];
          offset_d     = grant_addr[BLOCK_OFFSET_BITS-1:0];
          hit_d        = 1'b0;
          timeout_d    = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 8'd1;
        // A completion on the watchdog's last cycle still counts as normal.
        if (cache_updated) begin
          hit_d = cache_found;
          if (cache_found) hit_cnt_d = sat_inc(hit_cnt_q);
          else             miss_cnt_d = sat_inc(miss_cnt_q);
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          hit_d     = 1'b0;
          timeout_d = 1'b1;
          to_cnt_d  = sat_inc(to_cnt_q);
          to_flag_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      tag_q        <= '0;
      index_q      <= '0;
      offset_q     <= '0;
      wd_q         <= '0;
      hit_q        <= 1'b0;
      timeout_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      to_cnt_q     <= '0;
      to_flag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      offset_q     <= offset_d;
      wd_q         <= wd_d;
      hit_q        <= hit_d;
      timeout_q    <= timeout_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      to_cnt_q     <= to_cnt_d;
      to_flag_q    <= to_flag_d;
    end
  end

  // Response fields are forced low outside the response cycle.
  assign rsp_valid          = (state_q == RESP);
  assign rsp_id             = rsp_valid & id_q;
  assign rsp_hit            = rsp_valid & hit_q;
  assign rsp_timeout        = rsp_valid & timeout_q;
  assign cache_find_start   = (state_q == START);
  assign cache_tag          = tag_q;
  assign cache_index        = index_q;
  assign cache_block_offset = offset_q;
  assign hit_count          = hit_cnt_q;
  assign miss_count         = miss_cnt_q;
  assign timeout_count      = to_cnt_q;
  assign busy               = (state_q != IDLE);
  assign timeout_flag       = to_flag_q;

endmodule

// File: tb/tb_l1_access_arbiter.sv
// Randomized self-checking bench for l1_access_arbiter. The bench plays both
// requesters and the cache; a transaction-level model (pending requests,
// round-robin pointer, event counts) predicts every observable result.
// A second instance with 2-bit counters shares the stimulus to show saturation.
module tb_l1_access_arbiter;

  localparam int TIMEOUT = 255;
  localparam int CW      = 20;
  localparam int CW2     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_hit, rsp_timeout;
  logic        cache_find_start;
  logic [18:0] cache_tag;
  logic [8:0]  cache_index;
  logic [3:0]  cache_block_offset;
  logic        cache_found, cache_updated;
  logic [CW-1:0] hit_count, miss_count, timeout_count;
  logic        busy, timeout_flag;

  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_hit, s_rsp_timeout;
  logic        s_find_start, s_busy, s_timeout_flag;
  logic [18:0] s_tag;
  logic [8:0]  s_index;
  logic [3:0]  s_offset;
  logic [CW2-1:0] s_hit_count, s_miss_count, s_timeout_count;

  l1_access_arbiter #(.TIMEOUT(TIMEOUT), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout),
    .cache_find_start(cache_find_start), .cache_tag(cache_tag), .cache_index(cache_index),
    .cache_block_offset(cache_block_offset), .cache_found(cache_found),
    .cache_updated(cache_updated), .hit_count(hit_count), .miss_count(miss_count),
    .timeout_count(timeout_count), .busy(busy), .timeout_flag(timeout_flag)
  );

  l1_access_arbiter #(.TIMEOUT(TIMEOUT), .COUNT_WIDTH(CW2)) dut_small (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(s_req1_ready),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_hit(s_rsp_hit), .rsp_timeout(s_rsp_timeout),
    .cache_find_start(s_find_start), .cache_tag(s_tag), .cache_index(s_index),
    .cache_block_offset(s_offset), .cache_found(cache_found),
    .cache_updated(cache_updated), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .timeout_count(s_timeout_count), .busy(s_busy), .timeout_flag(s_timeout_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_last;
  int          m_hit, m_miss, m_to;
  bit          m_flag;
  bit          pend0, pend1;
  logic [31:0] pa0, pa1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return 32'((v > mx) ? mx : v);
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_hit = 0; m_miss = 0; m_to = 0; m_flag = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
  endtask

  task automatic check_counters();
    check_eq("hit_count", hit_count, sat(m_hit, CW));
    check_eq("miss_count", miss_count, sat(m_miss, CW));
    check_eq("timeout_count", timeout_count, sat(m_to, CW));
    check_eq("timeout_flag", timeout_flag, m_flag);
    check_eq("small_hit_count", s_hit_count, sat(m_hit, CW2));
    check_eq("small_miss_count", s_miss_count, sat(m_miss, CW2));
    check_eq("small_timeout_count", s_timeout_count, sat(m_to, CW2));
  endtask

  task automatic check_all_zero();
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    check_eq("rst_rsp", {rsp_valid, rsp_id, rsp_hit, rsp_timeout}, 0);
    check_eq("rst_find_start", cache_find_start, 0);
    check_eq("rst_addr", {cache_tag, cache_index, cache_block_offset}, 0);
    check_eq("rst_busy", busy, 0);
    check_counters();
  endtask

  // New requests appear on idle ports with probability pct; at least one exists.
  task automatic add_reqs(input int pct);
    if (!pend0 && $urandom_range(0, 99) < pct) begin pend0 = 1'b1; pa0 = $urandom; end
    if (!pend1 && $urandom_range(0, 99) < pct) begin pend1 = 1'b1; pa1 = $urandom; end
    if (!pend0 && !pend1) begin
      if ($urandom_range(0, 1) == 0) begin pend0 = 1'b1; pa0 = $urandom; end
      else begin pend1 = 1'b1; pa1 = $urandom; end
    end
  endtask

  // One full transaction. Entered and left just after a rising edge with the
  // DUT idle. upd_k is the WAIT cycle (0 = first) on which updated is raised.
  task automatic run_txn(input int upd_k, input bit found, input bit no_upd);
    bit          g;
    int          bad;
    logic [31:0] ga;
    g  = (pend0 && pend1) ? !m_last : pend1;
    ga = g ? pa1 : pa0;
    req0_valid = pend0; req0_addr = pa0;
    req1_valid = pend1; req1_addr = pa1;
    @(negedge clk);
    check_eq("idle_before_grant", busy, 0);
    check_eq("ready0", req0_ready, !g);
    check_eq("ready1", req1_ready, g);
    m_last = g;
    if (g) pend1 = 1'b0; else pend0 = 1'b0;
    @(posedge clk); #1;
    req0_valid = pend0; req1_valid = pend1;
    @(negedge clk);
    check_eq("find_start", cache_find_start, 1);
    check_eq("cache_tag", cache_tag, ga >> 13);
    check_eq("cache_index", cache_index, (ga >> 4) & 32'h1FF);
    check_eq("cache_offset", cache_block_offset, ga & 32'hF);
    check_eq("ready_in_start", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      cache_updated = !no_upd && (k == upd_k);
      cache_found   = cache_updated ? found : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rsp_valid || cache_find_start || req0_ready || req1_ready || !busy) bad++;
      if (no_upd ? (k == TIMEOUT - 1) : (k == upd_k)) break;
      @(posedge clk); #1;
    end
    check_eq("wait_quiet", bad, 0);
    @(posedge clk); #1;
    cache_updated = 1'b0; cache_found = 1'b0;
    @(negedge clk);
    if (no_upd) begin m_to++; m_flag = 1'b1; end
    else if (found) m_hit++;
    else m_miss++;
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_id", rsp_id, g);
    check_eq("rsp_hit", rsp_hit, !no_upd && found);
    check_eq("rsp_timeout", rsp_timeout, no_upd);
    check_counters();
    @(posedge clk); #1;
  endtask

  // Stray updated pulse while idle must be ignored.
  task automatic stray_update();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cache_updated = 1'b1; cache_found = 1'b1;
    @(negedge clk);
    check_eq("stray_busy", busy, 0);
    @(posedge clk); #1;
    cache_updated = 1'b0; cache_found = 1'b0;
    @(negedge clk);
    check_eq("stray_no_rsp", {rsp_valid, busy}, 0);
    check_counters();
    @(posedge clk); #1;
  endtask

  // Reset two cycles into WAIT: no response, everything back to zero.
  task automatic reset_mid();
    req0_valid = 1'b1; req0_addr = $urandom; req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("reset_mid_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero();
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
    cache_found = 1'b0; cache_updated = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero();
    @(posedge clk); #1;

    // Directed lookup: port 0, hit three cycles after find_start.
    pend0 = 1'b1; pa0 = 32'h12345678;
    run_txn(2, 1'b1, 1'b0);
    stray_update();

    // Port 1 with no completion: watchdog abort, then a normal transaction.
    pend1 = 1'b1; pa1 = $urandom;
    run_txn(0, 1'b0, 1'b1);
    pend0 = 1'b1; pa0 = $urandom;
    run_txn(1, 1'b0, 1'b0);

    reset_mid();

    // Both ports continuously valid from reset: 8 alternating grants.
    for (int i = 0; i < 8; i++) begin
      add_reqs(100);
      run_txn($urandom_range(0, 5), (i % 2) == 0, 1'b0);
    end
    check_eq("b2b_hits", hit_count, 4);
    check_eq("b2b_misses", miss_count, 4);

    // Completion on the watchdog's final cycle.
    add_reqs(100);
    run_txn(TIMEOUT - 1, 1'b1, 1'b0);

    // Randomized traffic with occasional timeouts.
    for (int i = 0; i < 40; i++) begin
      add_reqs(50);
      run_txn($urandom_range(0, 12), 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
    end
    stray_update();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_access_arbiter.md
# l1_access_arbiter

Sequences and shares the single-lookup L1 cache between two requesters: instruction fetch (port 0) and data (port 1). It does round-robin arbitration and splits the 32-bit address into tag, index and block offset. It then runs the cache's find_start / updated handshake, returns a hit/miss response tagged with the requester id, and keeps saturating hit, miss and timeout statistics. It sits between the trace/core request streams and the L1 cache, one transaction in flight at a time.

## Interface
- BLOCK_OFFSET_BITS, 4: block offset width (16-byte blocks).
- SET_INDEX_BITS, 9: set index width (32 KB, 4-way, 512 sets).
- TAG_BITS, 32-SET_INDEX_BITS-BLOCK_OFFSET_BITS (19): tag width.
- TIMEOUT, 255: maximum WAIT cycles before aborting; must be ≥ 16 and fit in 8 bits.
- COUNT_WIDTH, 20: width of each statistics counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  port-0 request; holds valid and addr stable until req0_ready.
- req0_addr  in  32  port-0 byte address.
- req0_ready  out  1  port-0 accepted this cycle.
- req1_valid, req1_addr, req1_ready  same as port 0, for port 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester of the response.
- rsp_hit  out  1  lookup hit; 0 when rsp_timeout.
- rsp_timeout  out  1  transaction aborted by watchdog.
- cache_find_start  out  1  one-cycle lookup start.
- cache_tag  out  TAG_BITS  addr[31:13].
- cache_index  out  SET_INDEX_BITS  addr[12:4].
- cache_block_offset  out  BLOCK_OFFSET_BITS  addr[3:0].
- cache_found  in  1  cache found_in_cache.
- cache_updated  in  1  cache updated; completion strobe.
- hit_count, miss_count, timeout_count  out  COUNT_WIDTH each  saturating statistics.
- busy  out  1  state ≠ IDLE.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE.**
  - If no valid request: stay in IDLE.
  - If one valid request: grant it.
  - If both valid: grant the port not granted last. last_grant resets to 1, so port 0 wins the first tie.
  - Granted reqN_ready=1, combinational, in IDLE only.
  - On grant: latch addr split onto cache_tag, cache_index, cache_block_offset; latch id; update last_grant; go to START.
  - Cache address outputs hold until the next grant.
- **START.** cache_find_start=1 for this cycle only; clear watchdog; go to WAIT.
- **WAIT.**
  - Watchdog increments each cycle.
  - If cache_updated=1: latch hit = cache_found; increment hit_count or miss_count; go to RESP.
  - Else if watchdog == TIMEOUT-1: latch hit=0 and timeout=1; increment timeout_count; set timeout_flag; go to RESP.
  - If cache_updated arrives on the same cycle as the timeout condition, cache_updated wins (normal completion).
- **RESP.** rsp_valid=1 with rsp_id, rsp_hit, rsp_timeout; go to IDLE. rsp_hit and rsp_timeout are never both 1.
- **Counters.** Increment by 1, saturate at all-ones, never wrap.
- **cache_updated outside WAIT.** Ignored; no counter change.
- **Requests outside IDLE.** Not accepted; ready stays 0.

## Timing
- Reset values: state IDLE; all outputs 0 (ready, rsp_*, find_start, cache address, counters, busy, timeout_flag); last_grant=1; watchdog 0.
- Reset mid-transaction aborts it with no response and no counter update. The cache shares the same reset.
- Cycle sequence:
  - Accept in cycle T.
  - cache_find_start high in cycle T+1.
  - WAIT from T+2.
  - cache_updated seen in cycle U gives rsp_valid in cycle U+1.
  - Next accept earliest in U+2. This lets the cache clear updated and return to its idle state before the next find_start.
- Timeout: with no completion, rsp_valid with rsp_timeout=1 in cycle T+2+TIMEOUT.
- Back-to-back: with both ports valid continuously, grants alternate 0,1,0,1.

## Test plan
- Port 0 request addr 0x12345678; cache returns updated=1, found=1 three cycles after find_start -> tag 0x091A2, index 0x167, offset 0x8; find_start one cycle at T+1; rsp_valid, id=0, hit=1; hit_count=1.
- Both ports valid from reset, 4 transactions each, alternating hit/miss -> grant order 0,1,0,1,…; 8 responses with correct ids; hit_count=4, miss_count=4; ≥1 idle cycle between rsp_valid and the next find_start.
- Port 1 request; cache never asserts updated -> rsp_valid, id=1, timeout=1, hit=0 at T+2+255; timeout_count=1; timeout_flag stays 1 until reset; next request is serviced normally.
- Assert reset during WAIT -> no rsp_valid; all outputs 0 the next cycle; a new port-0 request afterward completes normally.
- COUNT_WIDTH=2 build, 5 hits -> hit_count saturates at 3.
- Stray cache_updated pulse in IDLE, then updated and the timeout condition on the same cycle -> stray pulse ignored, no count; same-cycle case gives normal completion, timeout=0.
